// File: rtl/ram_wr_gen_pkg.sv
// Shared types and helpers for the RAM write-pattern generator.
package ram_wr_gen_pkg;

    // Data pattern selected at the start of a fill.
    typedef enum logic [1:0] {
        MODE_ADDR  = 2'd0,
        MODE_INV   = 2'd1,
        MODE_CONST = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } state_e;

    // Galois (right-shift) tap masks for maximal-length sequences, indexed by width.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            default: taps = 32'h8000_0057;
        endcase
        return taps;
    endfunction

    // One Galois step; upper bits beyond the width stay zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int unsigned width);
        return s[0] ? ((s >> 1) ^ lfsr_taps(width)) : (s >> 1);
    endfunction

endpackage

// File: rtl/ram_wr_gen_if.sv
// RAM write-port bundle driven by the generator (master) and consumed by the RAM side (slave).
interface ram_wr_gen_if
    import ram_wr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
);
    logic              ram_wr_en;
    logic              ram_wr_we;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_flag;

    modport master (
        output ram_wr_en,
        output ram_wr_we,
        output ram_wr_addr,
        output ram_wr_data,
        output ram_rd_flag
    );

    modport slave (
        input ram_wr_en,
        input ram_wr_we,
        input ram_wr_addr,
        input ram_wr_data,
        input ram_rd_flag
    );
endinterface

// File: rtl/ram_wr_lfsr.sv
// Galois LFSR pattern source; only instantiated when RAM_WR_GEN_LFSR_EN is defined.
module ram_wr_lfsr
    import ram_wr_gen_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              advance,
    output logic [DATA_W-1:0] state
);
    logic [DATA_W-1:0] state_q;

    // Load wins over advance; reset leaves the register all-ones so it never locks up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '1;
        end else if (load) begin
            state_q <= load_val;
        end else if (advance) begin
            state_q <= DATA_W'(lfsr_step(32'(state_q), DATA_W));
        end
    end

    assign state = state_q;
endmodule

// File: rtl/ram_wr_gen.sv
// RAM write-pattern generator: fills the RAM one word per cycle with a selectable pattern,
// optionally wrapping forever, and raises a sticky flag once the reader may begin.
// Define RAM_WR_GEN_LFSR_EN to enable the LFSR pattern (mode 3); otherwise mode 3 = mode 0.
module ram_wr_gen
    import ram_wr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_THRESH = 2 ** (ADDR_W - 1) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    ram_wr_gen_if.master      wr
);
    localparam logic [ADDR_W-1:0] AddrLast     = '1;
    localparam logic [ADDR_W-1:0] RdThreshAddr = ADDR_W'(RD_THRESH);

    state_e            state_q;
    logic              en_q, busy_q, done_q, rd_flag_q, cont_q;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, seed_q, first_word, next_word;
    mode_e             mode_q;
    logic              accept, advance;

    function automatic logic [DATA_W-1:0] pattern(input mode_e m, input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] aw, r;
        aw = DATA_W'(a);
        case (m)
            MODE_INV:   r = ~aw;
            MODE_CONST: r = s;
            default:    r = aw;
        endcase
        return r;
    endfunction

    assign accept   = (state_q == StIdle) && start && !stop;
    // Move on to another word unless this is the last address of a single pass.
    assign advance  = (state_q == StWrite) && !stop && ((addr_q != AddrLast) || cont_q);
    assign addr_nxt = addr_q + 1'b1;

`ifdef RAM_WR_GEN_LFSR_EN
    logic [DATA_W-1:0] lfsr_state, lfsr_seed, lfsr_next;

    assign lfsr_seed = (seed == '0) ? '1 : seed;
    assign lfsr_next = DATA_W'(lfsr_step(32'(lfsr_state), DATA_W));

    ram_wr_lfsr #(
        .DATA_W (DATA_W)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (lfsr_seed),
        .advance  (advance),
        .state    (lfsr_state)
    );
`endif

    // Word for the first address uses live inputs; later words use the latched settings.
    always_comb begin
        first_word = pattern(mode_e'(mode), '0, seed);
        next_word  = pattern(mode_q, addr_nxt, seed_q);
`ifdef RAM_WR_GEN_LFSR_EN
        if (mode_e'(mode) == MODE_LFSR) first_word = lfsr_seed;
        if (mode_q == MODE_LFSR)        next_word  = lfsr_next;
`endif
    end

    // Control FSM with all outputs registered; stop overrides everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_flag_q <= 1'b0;
            mode_q    <= MODE_ADDR;
            seed_q    <= '0;
            cont_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en_q && (addr_q == RdThreshAddr)) rd_flag_q <= 1'b1;
            if (stop) begin
                state_q <= StIdle;
                en_q    <= 1'b0;
                addr_q  <= '0;
                data_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q   <= StWrite;
                            en_q      <= 1'b1;
                            busy_q    <= 1'b1;
                            addr_q    <= '0;
                            data_q    <= first_word;
                            mode_q    <= mode_e'(mode);
                            seed_q    <= seed;
                            cont_q    <= cont;
                            rd_flag_q <= 1'b0;
                        end
                    end
                    StWrite: begin
                        if (advance) begin
                            addr_q <= addr_nxt;
                            data_q <= next_word;
                        end else begin
                            state_q <= StDone;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            addr_q  <= '0;
                            data_q  <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign wr.ram_wr_en   = en_q;
    assign wr.ram_wr_we   = en_q;
    assign wr.ram_wr_addr = addr_q;
    assign wr.ram_wr_data = data_q;
    assign wr.ram_rd_flag = rd_flag_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_ram_wr_gen.sv
// Self-checking bench for ram_wr_gen with a word-index based reference model.
module tb_ram_wr_gen;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int          DEPTH  = 64;

    logic       clk = 1'b0;
    logic       rst, start, stop, cont;
    logic [1:0] mode;
    logic [7:0] seed;
    logic       busy, done;
    int         n_tests = 0;
    int         n_fail  = 0;

    ram_wr_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_wr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .mode  (mode),
        .seed  (seed),
        .busy  (busy),
        .done  (done),
        .wr    (bus)
    );

    always #5 clk = ~clk;

    // {en, we, addr, data, rd_flag, busy, done}
    logic [18:0] act;
    assign act = {bus.ram_wr_en, bus.ram_wr_we, bus.ram_wr_addr, bus.ram_wr_data,
                  bus.ram_rd_flag, busy, done};

    function automatic logic [18:0] vec(bit en, int addr, logic [7:0] data, bit rd, bit bsy,
                                        bit dn);
        return {en, en, 6'(addr), data, rd, bsy, dn};
    endfunction

    // State of an x^8+x^6+x^5+x^4+1 Galois register after n steps from the seed.
    function automatic logic [7:0] lfsr_nth(logic [7:0] sd, int n);
        logic [7:0] s;
        s = (sd == 8'h00) ? 8'hFF : sd;
        for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
        return s;
    endfunction

    // Expected data for the idx-th word written since start.
    function automatic logic [7:0] model_word(int m, logic [7:0] sd, int idx);
        logic [7:0] a;
        a = 8'(idx % DEPTH);
        case (m)
            1:       return ~a;
            2:       return sd;
`ifdef RAM_WR_GEN_LFSR_EN
            3:       return lfsr_nth(sd, idx);
`endif
            default: return a;
        endcase
    endfunction

    task automatic launch(int m, logic [7:0] sd, bit c);
        @(negedge clk);
        mode  = 2'(m);
        seed  = sd;
        cont  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (act !== vec(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", act, vec(0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (act !== vec(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_idle got=%h exp=%h", act, vec(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_addr_pass();
        logic [18:0] exp;
        launch(0, 8'h00, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            exp = vec(1, k, model_word(0, 8'h00, k), k > 31, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL addr_pass k=%0d got=%h exp=%h", k, act, exp);
            end
            @(negedge clk);
        end
        n_tests++;
        if (act !== vec(0, 0, 0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL addr_done got=%h exp=%h", act, vec(0, 0, 0, 1, 0, 1));
        end
        @(negedge clk);
        n_tests++;
        if (act !== vec(0, 0, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL addr_after_done got=%h exp=%h", act, vec(0, 0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_const_inv();
        logic [18:0] exp;
        for (int m = 2; m >= 1; m--) begin
            launch(m, 8'hA5, 1'b0);
            for (int k = 0; k < DEPTH; k++) begin
                exp = vec(1, k, (m == 2) ? 8'hA5 : ~8'(k), k > 31, 1, 0);
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL const_inv m=%0d k=%0d got=%h exp=%h", m, k, act, exp);
                end
                if (m == 1 && k == 5) begin
                    n_tests++;
                    if (bus.ram_wr_data !== 8'hFA) begin
                        n_fail++;
                        $display("FAIL inv_addr5 got=%h exp=fa", bus.ram_wr_data);
                    end
                end
                @(negedge clk);
            end
            n_tests++;
            if (act !== vec(0, 0, 0, 1, 0, 1)) begin
                n_fail++;
                $display("FAIL const_inv_done got=%h exp=%h", act, vec(0, 0, 0, 1, 0, 1));
            end
        end
    endtask

    task automatic test_cont_wrap();
        logic [18:0] exp;
        launch(0, 8'h00, 1'b1);
        for (int k = 0; k < 150; k++) begin
            exp = vec(1, k % DEPTH, model_word(0, 8'h00, k), k > 31, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cont_wrap k=%0d got=%h exp=%h", k, act, exp);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cont = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (act !== vec(0, 0, 0, 1, 0, 0)) begin
                n_fail++;
                $display("FAIL cont_stop i=%0d got=%h exp=%h", i, act, vec(0, 0, 0, 1, 0, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stop();
        logic [18:0] exp;
        launch(0, 8'h00, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            exp = vec(1, k, model_word(0, 8'h00, k), 0, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL stop_pre k=%0d got=%h exp=%h", k, act, exp);
            end
            if (k < 10) @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (act !== vec(0, 0, 0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL stop_idle i=%0d got=%h exp=%h", i, act, vec(0, 0, 0, 0, 0, 0));
            end
            @(negedge clk);
        end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act !== vec(0, 0, 0, 0, 0, 0)) begin
                n_fail++;
                $display("FAIL start_with_stop i=%0d got=%h exp=%h", i, act,
                         vec(0, 0, 0, 0, 0, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        logic [18:0] exp;
        launch(2, 8'h3C, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            exp = vec(1, k, 8'h3C, k > 31, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL busy_start k=%0d got=%h exp=%h", k, act, exp);
            end
            if (k == 5) begin
                start = 1'b1;
                mode  = 2'd0;
                seed  = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (act !== vec(0, 0, 0, 1, 0, 1)) begin
            n_fail++;
            $display("FAIL ign_done got=%h exp=%h", act, vec(0, 0, 0, 1, 0, 1));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (act !== vec(0, 0, 0, 1, 0, 0)) begin
                n_fail++;
                $display("FAIL done_start i=%0d got=%h exp=%h", i, act, vec(0, 0, 0, 1, 0, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid();
        logic [18:0] exp;
        launch(0, 8'h00, 1'b0);
        for (int k = 0; k <= 40; k++) begin
            exp = vec(1, k, model_word(0, 8'h00, k), k > 31, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL rst_pre k=%0d got=%h exp=%h", k, act, exp);
            end
            if (k < 40) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (act !== vec(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL rst_mid got=%h exp=%h", act, vec(0, 0, 0, 0, 0, 0));
        end
        launch(0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp = vec(1, k, model_word(0, 8'h00, k), 0, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL rst_restart k=%0d got=%h exp=%h", k, act, exp);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_lfsr();
        logic [18:0] exp;
        logic [7:0]  sd, first;
`ifdef RAM_WR_GEN_LFSR_EN
        first = 8'hFF;
`else
        first = 8'h00;
`endif
        launch(3, 8'h00, 1'b0);
        n_tests++;
        if (bus.ram_wr_data !== first) begin
            n_fail++;
            $display("FAIL lfsr_first got=%h exp=%h", bus.ram_wr_data, first);
        end
        for (int k = 0; k < DEPTH; k++) begin
            exp = vec(1, k, model_word(3, 8'h00, k), k > 31, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL lfsr_zero k=%0d got=%h exp=%h", k, act, exp);
            end
            @(negedge clk);
        end
        sd = 8'($urandom_range(1, 255));
        launch(3, sd, 1'b1);
        for (int k = 0; k < 300; k++) begin
            exp = vec(1, k % DEPTH, model_word(3, sd, k), k > 31, 1, 0);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL lfsr_cont seed=%h k=%0d got=%h exp=%h", sd, k, act, exp);
            end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cont = 1'b0;
    endtask

    task automatic test_random();
        logic [18:0] exp;
        logic [7:0]  sd;
        int          m;
        for (int p = 0; p < 6; p++) begin
            m  = int'($urandom_range(0, 3));
            sd = 8'($urandom);
            launch(m, sd, 1'b0);
            for (int k = 0; k < DEPTH; k++) begin
                exp = vec(1, k, model_word(m, sd, k), k > 31, 1, 0);
                n_tests++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL random m=%0d seed=%h k=%0d got=%h exp=%h", m, sd, k, act, exp);
                end
                @(negedge clk);
            end
            n_tests++;
            if (act !== vec(0, 0, 0, 1, 0, 1)) begin
                n_fail++;
                $display("FAIL random_done p=%0d got=%h exp=%h", p, act, vec(0, 0, 0, 1, 0, 1));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        cont  = 1'b0;
        mode  = 2'd0;
        seed  = 8'h00;
        test_reset();
        test_addr_pass();
        test_const_inv();
        test_cont_wrap();
        test_stop();
        test_start_ignored();
        test_rst_mid();
        test_lfsr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_wr_gen.md
RAM_WR_GEN -- requirements
Module: ram_wr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width (depth = 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, RAM write-data width.
REQ-003 SHALL have parameter RD_THRESH, default 2**(ADDR_W-1)-1, address whose write arms the reader.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse to begin a fill.
REQ-007 SHALL have port stop  input  1  abort request.
REQ-008 SHALL have port cont  input  1  1 = wrap and refill forever; 0 = single pass.
REQ-009 SHALL have port mode  input  2  data pattern select, sampled on accepted start.
REQ-010 SHALL have port seed  input  DATA_W  constant or LFSR seed, sampled on accepted start.
REQ-011 SHALL have port ram_wr_en  output  1  RAM port enable.
REQ-012 SHALL have port ram_wr_we  output  1  RAM write enable, equal to ram_wr_en.
REQ-013 SHALL have port ram_wr_addr  output  ADDR_W  write address.
REQ-014 SHALL have port ram_wr_data  output  DATA_W  write data.
REQ-015 SHALL have port ram_rd_flag  output  1  sticky "reader may start".
REQ-016 SHALL have ports busy (1, high in WRITE) and done (1, one-cycle pulse at pass end).

Function
REQ-017 SHALL implement FSM IDLE, WRITE, DONE; ram_wr_en, ram_wr_addr, ram_wr_data, busy and done all registered.
REQ-018 IDLE: start=1 and stop=0 -> WRITE next cycle with ram_wr_addr=0, ram_wr_en=1, first word on the bus; mode, seed and cont latched.
REQ-019 WRITE: one word per cycle, address +1 per cycle, no gaps.
REQ-020 WRITE at address 2**ADDR_W-1: cont=1 -> address wraps to 0, stays in WRITE; cont=0 -> DONE, ram_wr_en=0 next cycle.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 stop=1 in any state -> IDLE next cycle, ram_wr_en=0, address 0, no done pulse; stop wins over simultaneous start.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 mode 0 ADDR: data = address zero-extended or truncated to DATA_W.
REQ-025 mode 1 INV: data = bitwise inverse of mode-0 value.
REQ-026 mode 2 CONST: data = latched seed.
REQ-027 mode 3 LFSR: data = Galois LFSR state, seeded at start (zero seed replaced by all-ones), advanced once per written word.
REQ-028 ram_rd_flag SHALL set on the edge after the write to RD_THRESH, hold until reset or the next accepted start, and clear on that start.
REQ-029 Outside WRITE, ram_wr_data SHALL hold 0.

Reset
REQ-030 rst=1 SHALL force IDLE, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, ram_rd_flag=0, busy=0, done=0, LFSR=all-ones; applies mid-pass.

Configuration
REQ-031 Macro RAM_WR_GEN_LFSR_EN defined: mode 3 as REQ-027.
REQ-032 Macro absent: no LFSR logic; mode 3 behaves as mode 0.

Structure
REQ-033 Package ram_wr_gen_pkg SHALL hold the mode enum (MODE_ADDR, MODE_INV, MODE_CONST, MODE_LFSR), the FSM state typedef and the LFSR tap constants per DATA_W.
REQ-034 LFSR SHALL be sub-module ram_wr_lfsr (load, advance, state), instantiated only under RAM_WR_GEN_LFSR_EN.

Verification
REQ-035 Defaults, mode 0, cont=0, start pulse -> 64 writes, addr 0..63, data 0x00..0x3F, done one cycle after last write, busy=0 after.
REQ-036 Defaults, cont=1 -> addr 63 followed by 0 with no gap; ram_rd_flag rises the cycle after addr 31, stays high across wraps.
REQ-037 mode 2, seed 0xA5 -> all 64 words 0xA5; mode 1 -> addr 5 carries 0xFA.
REQ-038 stop asserted at addr 10 -> ram_wr_en=0 next cycle, no done; start with stop same cycle in IDLE -> stays IDLE.
REQ-039 rst asserted at addr 40 -> all outputs reset values next cycle; new start clears ram_rd_flag and restarts at 0.
REQ-040 LFSR_EN defined, mode 3, seed 0 -> first word 0xFF, sequence matches reference model; macro undefined -> matches mode 0.
